// File: rtl/rr_arb_pkg.sv
// Shared types, constants and the wrapped priority search for the round-robin arbiter.
package rr_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Width of the consecutive-grant counter; saturates at its all-ones value.
    localparam int unsigned HOLD_CNT_W = 8;

    // Largest supported requester count and the index width that covers it.
    localparam int unsigned MAX_NREQ  = 16;
    localparam int unsigned IDX_MAX_W = 4;

    // Search result: {found, index}.
    localparam int unsigned SRCH_W = IDX_MAX_W + 1;

    // First set bit of elig at or above ptr, wrapping at nreq-1 back to 0.
    // The loop bound is a constant so the search unrolls into a fixed priority mux.
    function automatic logic [SRCH_W-1:0] rr_search(
        input logic [MAX_NREQ-1:0]  elig,
        input logic [IDX_MAX_W-1:0] ptr,
        input int unsigned          nreq
    );
        logic [SRCH_W-1:0] res;
        int unsigned       j;
        res = '0;
        j   = 0;
        for (int unsigned k = 0; k < MAX_NREQ; k++) begin
            if (k < nreq) begin
                j = (32'(ptr) + k) % nreq;
                if (!res[SRCH_W-1] && elig[IDX_MAX_W'(j)]) begin
                    res = {1'b1, IDX_MAX_W'(j)};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
interface rr_onehot_arbiter_if
    import rr_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDXW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            gnt_valid;
    logic [IDXW-1:0] gnt_idx;
    logic            preempt;

    // Arbiter side: consumes requests, produces the grant outputs.
    modport master (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_idx,
        output preempt
    );

    // Requester side: drives requests, observes the grant outputs.
    modport slave (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_idx,
        input  preempt
    );

endinterface

// File: rtl/arb_idx_to_onehot.sv
// Combinational binary-index to one-hot decoder feeding the grant register.
module arb_idx_to_onehot
    import rr_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [$clog2(NREQ)-1:0] idx,
    output logic [NREQ-1:0]         onehot_c
);

    // Exactly one bit set at position idx; NREQ is a power of two so every idx is legal.
    always_comb begin
        onehot_c      = '0;
        onehot_c[idx] = 1'b1;
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with binary winner pointer, one-hot grant, bounded hold and preemption.
module rr_onehot_arbiter
    import rr_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst_n,
    rr_onehot_arbiter_if.master bus
);

    localparam int unsigned            IDXW         = $clog2(NREQ);
    localparam bit                     HOLD_LIMITED = (MAX_HOLD != 0);
    localparam logic [HOLD_CNT_W-1:0]  HOLD_LIMIT   = HOLD_CNT_W'(MAX_HOLD);
    localparam logic [HOLD_CNT_W-1:0]  HOLD_SAT     = '1;

    arb_state_e             state;
    logic [IDXW-1:0]        ptr;
    logic [NREQ-1:0]        mask;
    logic [HOLD_CNT_W-1:0]  hold_cnt;

    logic [NREQ-1:0]        eligible_c;
    logic [SRCH_W-1:0]      srch_c;
    logic                   win_found_c;
    logic [IDXW-1:0]        win_idx_c;
    logic [NREQ-1:0]        win_onehot_c;
    logic                   owner_req_c;
    logic                   hold_expired_c;

    // Winner selection among unmasked requesters, starting from the pointer.
    always_comb begin
        eligible_c     = bus.req & ~mask;
        srch_c         = rr_search(MAX_NREQ'(eligible_c), IDX_MAX_W'(ptr), NREQ);
        win_found_c    = srch_c[SRCH_W-1];
        win_idx_c      = IDXW'(srch_c[SRCH_W-2:0]);
        owner_req_c    = bus.req[bus.gnt_idx];
        hold_expired_c = HOLD_LIMITED && (hold_cnt == HOLD_LIMIT);
    end

    // Winner index to one-hot grant vector.
    arb_idx_to_onehot #(
        .NREQ (NREQ)
    ) u_idx_to_onehot (
        .idx      (win_idx_c),
        .onehot_c (win_onehot_c)
    );

    // Arbiter FSM with registered grant outputs; async reset drops any grant immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            mask          <= '0;
            hold_cnt      <= '0;
            bus.gnt       <= '0;
            bus.gnt_valid <= 1'b0;
            bus.gnt_idx   <= '0;
            bus.preempt   <= 1'b0;
        end else begin
            bus.preempt <= 1'b0;
            // A dropped request always clears its mask bit, re-arming a preempted agent.
            mask        <= mask & bus.req;
            unique case (state)
                IDLE: begin
                    if (win_found_c) begin
                        bus.gnt       <= win_onehot_c;
                        bus.gnt_idx   <= win_idx_c;
                        bus.gnt_valid <= 1'b1;
                        hold_cnt      <= HOLD_CNT_W'(1);
                        state         <= GRANT;
                    end else begin
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!owner_req_c) begin
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                        ptr           <= bus.gnt_idx + IDXW'(1);
                        state         <= IDLE;
                    end else if (hold_expired_c) begin
                        // gnt is onehot(gnt_idx) here, so it doubles as the mask bit to set.
                        bus.gnt       <= '0;
                        bus.gnt_valid <= 1'b0;
                        bus.preempt   <= 1'b1;
                        mask          <= (mask & bus.req) | bus.gnt;
                        ptr           <= bus.gnt_idx + IDXW'(1);
                        state         <= IDLE;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HOLD_CNT_W'(1);
                    end
                end
                default: begin
                    bus.gnt       <= '0;
                    bus.gnt_valid <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter with a per-cycle expectation scoreboard.
module tb_rr_onehot_arbiter;

    localparam int unsigned NREQ     = 4;
    localparam int unsigned MAX_HOLD = 8;

    typedef struct packed {
        logic [3:0] gnt;
        logic       valid;
        logic [1:0] idx;
        logic       pre;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // Reference model state
    bit         m_busy;
    int         m_ptr;
    logic [3:0] m_mask;
    int         m_hold;
    logic [3:0] m_gnt;
    int         m_idx;
    bit         m_pre;
    logic       prev_pre;
    int         hold_seen;

    always #5 clk = ~clk;

    rr_onehot_arbiter_if #(.NREQ(NREQ)) bus ();

    rr_onehot_arbiter #(
        .NREQ     (NREQ),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy   = 1'b0;
        m_ptr    = 0;
        m_mask   = '0;
        m_hold   = 0;
        m_gnt    = '0;
        m_idx    = 0;
        m_pre    = 1'b0;
        prev_pre = 1'b0;
    endtask

    // One rising edge of the intended behaviour with requests r.
    task automatic model_edge(input logic [3:0] r);
        logic [3:0] elig;
        bit         found;
        bit         do_pre;
        int         w;
        int         j;
        elig   = r & ~m_mask;
        found  = 1'b0;
        do_pre = 1'b0;
        w      = 0;
        m_pre  = 1'b0;
        if (!m_busy) begin
            for (int k = 0; k < 4; k++) begin
                j = (m_ptr + k) % 4;
                if (!found && elig[j]) begin
                    found = 1'b1;
                    w     = j;
                end
            end
            if (found) begin
                m_gnt  = 4'b0001 << w;
                m_idx  = w;
                m_hold = 1;
                m_busy = 1'b1;
            end else begin
                m_gnt = '0;
            end
        end else if (!r[m_idx]) begin
            m_gnt  = '0;
            m_ptr  = (m_idx + 1) % 4;
            m_busy = 1'b0;
        end else if (MAX_HOLD != 0 && m_hold == MAX_HOLD) begin
            m_gnt  = '0;
            m_pre  = 1'b1;
            do_pre = 1'b1;
            m_ptr  = (m_idx + 1) % 4;
            m_busy = 1'b0;
        end else if (m_hold < 255) begin
            m_hold++;
        end
        m_mask = m_mask & r;
        if (do_pre) m_mask[m_idx] = 1'b1;
    endtask

    // Drive r from a falling edge, score the outputs after the next rising edge, return on the falling edge.
    task automatic step(input logic [3:0] r);
        exp_t e;
        bus.req = r;
        model_edge(r);
        e.gnt   = m_gnt;
        e.valid = |m_gnt;
        e.idx   = 2'(m_idx);
        e.pre   = m_pre;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("gnt",       32'(bus.gnt),       32'(e.gnt));
        chk("gnt_valid", 32'(bus.gnt_valid), 32'(e.valid));
        chk("gnt_idx",   32'(bus.gnt_idx),   32'(e.idx));
        chk("preempt",   32'(bus.preempt),   32'(e.pre));
        chk("onehot0",   32'($onehot0(bus.gnt)), 32'd1);
        chk("valid_or",  32'(bus.gnt_valid), 32'(|bus.gnt));
        if (bus.gnt_valid) chk("gnt_at_idx", 32'(bus.gnt[bus.gnt_idx]), 32'd1);
        chk("preempt_pair", 32'(prev_pre & bus.preempt), 32'd0);
        prev_pre = bus.preempt;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r;
        int         idx;

        // Reset held with all requests high.
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        model_reset();
        repeat (5) begin
            @(negedge clk);
            chk("rst_gnt",   32'(bus.gnt),       32'd0);
            chk("rst_valid", 32'(bus.gnt_valid), 32'd0);
            chk("rst_idx",   32'(bus.gnt_idx),   32'd0);
            chk("rst_pre",   32'(bus.preempt),   32'd0);
        end
        rst_n = 1'b1;
        step(4'b1111);
        chk("first_gnt", 32'(bus.gnt), 32'h1);

        // Fairness: each winner holds two cycles, then drops and re-raises.
        step(4'b1111);
        step(4'b1110);
        chk("fair_dead0", 32'(bus.gnt), 32'h0);
        for (int w = 1; w <= 4; w++) begin
            idx = w % 4;
            step(4'b1111);
            chk("fair_order", 32'(bus.gnt_idx), 32'(idx));
            step(4'b1111);
            chk("fair_hold", 32'(bus.gnt), 32'(4'b0001 << idx));
            r = 4'b1111 & ~(4'b0001 << idx);
            step(r);
            chk("fair_dead", 32'(bus.gnt), 32'h0);
        end
        step(4'b0000);

        // Single requester for three cycles.
        step(4'b0100);
        chk("single_gnt", 32'(bus.gnt), 32'h4);
        chk("single_idx", 32'(bus.gnt_idx), 32'd2);
        step(4'b0100);
        step(4'b0100);
        chk("single_gnt3", 32'(bus.gnt), 32'h4);
        step(4'b0000);
        chk("single_drop", 32'(bus.gnt), 32'h0);

        // Wrap: pointer at 3 after releasing 2.
        step(4'b1001);
        chk("wrap_first", 32'(bus.gnt), 32'h8);
        step(4'b0001);
        step(4'b0001);
        chk("wrap_second", 32'(bus.gnt), 32'h1);
        step(4'b0000);

        // Preemption: requester 1 stuck high, requester 3 waiting.
        hold_seen = 0;
        for (int c = 0; c < 8; c++) begin
            step(4'b1010);
            if (bus.gnt[1]) hold_seen++;
        end
        step(4'b1010);
        if (bus.gnt[1]) hold_seen++;
        chk("hold_len", 32'(hold_seen), 32'd8);
        chk("preempt_pulse", 32'(bus.preempt), 32'd1);
        chk("preempt_gnt", 32'(bus.gnt), 32'h0);
        step(4'b1010);
        chk("after_preempt", 32'(bus.gnt), 32'h8);
        chk("preempt_single", 32'(bus.preempt), 32'd0);
        step(4'b1010);
        step(4'b0010);
        step(4'b0010);
        chk("masked_1a", 32'(bus.gnt), 32'h0);
        step(4'b0010);
        chk("masked_1b", 32'(bus.gnt), 32'h0);
        step(4'b0000);
        step(4'b0010);
        chk("regrant_1", 32'(bus.gnt), 32'h2);

        // Reset asserted mid-grant clears outputs without a clock edge.
        step(4'b0010);
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt",   32'(bus.gnt),       32'h0);
        chk("async_rst_valid", 32'(bus.gnt_valid), 32'd0);
        chk("async_rst_idx",   32'(bus.gnt_idx),   32'd0);
        model_reset();
        @(negedge clk);
        chk("rst_hold_gnt", 32'(bus.gnt), 32'h0);
        rst_n = 1'b1;
        step(4'b0010);
        chk("post_rst_gnt", 32'(bus.gnt), 32'h2);
        step(4'b0000);
        step(4'b1010);
        chk("post_rst_ptr", 32'(bus.gnt_idx), 32'd3);
        step(4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
